// File: rtl/rdyacpt_fifo.sv
// Parametrised rdy/acpt FIFO with fill level, almost-full flag and synchronous flush.
// Define RDYACPT_FIFO_PARITY_EN to store even parity per entry and flag head-word mismatches.
module rdyacpt_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       upstream_rdy,
  input  logic [WIDTH-1:0]           upstream_data,
  output logic                       upstream_acpt,
  output logic                       downstream_rdy,
  output logic [WIDTH-1:0]           downstream_data,
  input  logic                       downstream_acpt,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       downstream_perr
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_THRESH);

  if (DEPTH < 2) begin : g_depth_chk
    $error("rdyacpt_fifo: DEPTH must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_thresh_chk
    $error("rdyacpt_fifo: AFULL_THRESH must lie in 1..DEPTH");
  end
  if (WIDTH < 1) begin : g_width_chk
    $error("rdyacpt_fifo: WIDTH must be at least 1");
  end

  logic [PtrW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  // Handshake outputs depend only on registered count and flush, never on the far side.
  assign upstream_acpt  = (cnt_q != FullCnt) & ~flush;
  assign downstream_rdy = (cnt_q != '0) & ~flush;
  assign push           = upstream_rdy & upstream_acpt;
  assign pop            = downstream_rdy & downstream_acpt;

  assign downstream_data = mem_q[rp_q];
  assign level           = cnt_q;
  assign almost_full     = (cnt_q >= AfullCnt);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (push) wp_d = (wp_q == LastPtr) ? '0 : wp_q + PtrW'(1);
      if (pop)  rp_d = (rp_q == LastPtr) ? '0 : rp_q + PtrW'(1);
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (!push && pop) cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= upstream_data;
  end

`ifdef RDYACPT_FIFO_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk) begin
    if (push) par_q[wp_q] <= ^upstream_data;
  end

  assign downstream_perr = downstream_rdy & (par_q[rp_q] != ^downstream_data);
`else
  assign downstream_perr = 1'b0;
`endif

endmodule

// File: tb/tb_rdyacpt_fifo.sv
// Bench for rdyacpt_fifo: a DEPTH=4 instance for directed tests and a DEPTH=3 instance
// for random wrap-around traffic, each checked against a queue-based scoreboard.
module tb_rdyacpt_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] flush, up_rdy, dn_acpt;
  logic [7:0] up_data [2];
  bit         perr_inj [2];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pop [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Dep = (g == 0) ? 4 : 3;
    localparam int unsigned Af  = (g == 0) ? 3 : 2;

    logic [$clog2(Dep+1)-1:0] lvl;
    logic                     acpt, rdy, af, pe;
    logic [7:0]               dd;
    int                       cnt_m;
    byte unsigned             q [$];

    rdyacpt_fifo #(
      .WIDTH       (8),
      .DEPTH       (Dep),
      .AFULL_THRESH(Af)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush          (flush[g]),
      .upstream_rdy   (up_rdy[g]),
      .upstream_data  (up_data[g]),
      .upstream_acpt  (acpt),
      .downstream_rdy (rdy),
      .downstream_data(dd),
      .downstream_acpt(dn_acpt[g]),
      .level          (lvl),
      .almost_full    (af),
      .downstream_perr(pe)
    );

    // Stimulus side: record every word the model says is accepted at this edge.
    always @(posedge clk or negedge reset_n) begin : sb_push
      bit psh, pp;
      if (!reset_n || flush[g]) begin
        cnt_m = 0;
        q.delete();
      end else begin
        psh = up_rdy[g] && (cnt_m != Dep);
        pp  = dn_acpt[g] && (cnt_m != 0);
        if (psh) q.push_back(up_data[g]);
        cnt_m = cnt_m + int'(psh) - int'(pp);
      end
    end

    // Monitor: compare flags every cycle and pop/compare data on each transfer.
    always @(negedge clk) begin
      if (reset_n) begin
        chk($sformatf("level[%0d]", g), int'(lvl), cnt_m);
        chk($sformatf("upstream_acpt[%0d]", g), int'(acpt),
            int'((cnt_m != Dep) && !flush[g]));
        chk($sformatf("downstream_rdy[%0d]", g), int'(rdy), int'((cnt_m != 0) && !flush[g]));
        chk($sformatf("almost_full[%0d]", g), int'(af), int'(cnt_m >= Af));
        chk($sformatf("downstream_perr[%0d]", g), int'(pe), int'(perr_inj[g]));
        if (rdy && dn_acpt[g]) begin
          n_pop[g]++;
          if (q.size() == 0) chk($sformatf("pop_on_empty[%0d]", g), 1, 0);
          else chk($sformatf("downstream_data[%0d]", g), int'(dd), int'(q.pop_front()));
        end
      end
    end
  end

  task automatic directed();
    int p0;
    // Fill, stall and overflow.
    dn_acpt[0] = 1'b0;
    up_rdy[0]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data[0] = 8'(8'hA0 + i);
      step();
      if (i == 1) chk("afull_after_2", int'(g_dut[0].af), 0);
      if (i == 2) chk("afull_after_3", int'(g_dut[0].af), 1);
    end
    up_data[0] = 8'hA4;
    step();
    step();
    chk("full_level", int'(g_dut[0].lvl), 4);
    chk("full_acpt", int'(g_dut[0].acpt), 0);
    chk("full_head", int'(g_dut[0].dd), 'hA0);

    // Full with both sides active: pop only at edge N, push at N+1.
    up_data[0] = 8'hB0;
    dn_acpt[0] = 1'b1;
    step();
    chk("full_pop_only_level", int'(g_dut[0].lvl), 3);
    chk("acpt_after_pop", int'(g_dut[0].acpt), 1);
    step();
    chk("push_pop_level", int'(g_dut[0].lvl), 3);
    up_rdy[0] = 1'b0;
    repeat (3) step();
    chk("drained_level", int'(g_dut[0].lvl), 0);

    // Flush with both handshakes requested.
    dn_acpt[0] = 1'b0;
    up_rdy[0]  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      up_data[0] = 8'(8'hC0 + i);
      step();
    end
    up_data[0] = 8'hC2;
    dn_acpt[0] = 1'b1;
    flush[0]   = 1'b1;
    #1;
    chk("flush_acpt", int'(g_dut[0].acpt), 0);
    chk("flush_rdy", int'(g_dut[0].rdy), 0);
    step();
    flush[0]   = 1'b0;
    up_rdy[0]  = 1'b0;
    dn_acpt[0] = 1'b0;
    chk("post_flush_level", int'(g_dut[0].lvl), 0);

    // Reset mid-stream with three words held.
    up_rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_data[0] = 8'(8'hD0 + i);
      step();
    end
    up_rdy[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_acpt", int'(g_dut[0].acpt), 1);
    chk("rst_rdy", int'(g_dut[0].rdy), 0);
    chk("rst_level", int'(g_dut[0].lvl), 0);
    chk("rst_afull", int'(g_dut[0].af), 0);
    chk("rst_perr", int'(g_dut[0].pe), 0);
    reset_n = 1'b1;
    step();
    up_rdy[0]  = 1'b1;
    up_data[0] = 8'h11;
    step();
    up_rdy[0] = 1'b0;
    chk("after_rst_level", int'(g_dut[0].lvl), 1);
    chk("after_rst_data", int'(g_dut[0].dd), 'h11);
    dn_acpt[0] = 1'b1;
    step();
    dn_acpt[0] = 1'b0;
    chk("after_rst_empty", int'(g_dut[0].lvl), 0);

`ifdef RDYACPT_FIFO_PARITY_EN
    // Corrupt stored parity of the head word.
    up_rdy[0]  = 1'b1;
    up_data[0] = 8'h5A;
    step();
    up_rdy[0] = 1'b0;
    force g_dut[0].u_dut.par_q = '1;
    perr_inj[0] = 1'b1;
    #1;
    chk("perr_injected", int'(g_dut[0].pe), 1);
    dn_acpt[0] = 1'b1;
    step();
    perr_inj[0] = 1'b0;
    release g_dut[0].u_dut.par_q;
    dn_acpt[0] = 1'b0;
    chk("perr_after_pop", int'(g_dut[0].pe), 0);
`endif

    // Streaming at one word per cycle.
    p0         = n_pop[0];
    up_rdy[0]  = 1'b1;
    dn_acpt[0] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      up_data[0] = 8'($urandom);
      step();
    end
    chk("stream_level", int'(g_dut[0].lvl), 1);
    up_rdy[0] = 1'b0;
    step();
    step();
    dn_acpt[0] = 1'b0;
    chk("stream_pops", n_pop[0] - p0, 1000);
  endtask

  task automatic wrap();
    for (int i = 0; i < 500; i++) begin
      up_rdy[1]  = 1'($urandom_range(0, 1));
      dn_acpt[1] = 1'($urandom_range(0, 1));
      up_data[1] = 8'($urandom);
      step();
    end
    up_rdy[1]  = 1'b0;
    dn_acpt[1] = 1'b1;
    repeat (5) step();
    dn_acpt[1] = 1'b0;
    chk("wrap_drained", int'(g_dut[1].lvl), 0);
  endtask

  initial begin
    flush      = '0;
    up_rdy     = '0;
    dn_acpt    = '0;
    up_data[0] = '0;
    up_data[1] = '0;
    perr_inj   = '{1'b0, 1'b0};
    n_pop      = '{0, 0};
    reset_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_acpt", int'(g_dut[0].acpt), 1);
    chk("reset_rdy", int'(g_dut[0].rdy), 0);
    chk("reset_level", int'(g_dut[0].lvl), 0);
    chk("reset_afull", int'(g_dut[0].af), 0);
    chk("reset_perr", int'(g_dut[0].pe), 0);
    reset_n = 1'b1;
    fork
      directed();
      wrap();
    join
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rdyacpt_fifo.md
# rdyacpt_fifo

Parametrised ready/accept buffer for the interleaver datapath, and the next generation of the two-entry ready/accept stage. It holds DEPTH words between an upstream producer and a downstream consumer. Both sides use the team's rdy/acpt handshake, and neither `upstream_acpt` nor `downstream_rdy` has a combinational path from the opposite side's handshake input. It adds a fill level, an almost-full flag, a synchronous flush and optional per-entry parity.

## Interface
- `WIDTH`, default 8: data word width in bits, at least 1.
- `DEPTH`, default 4: number of storage entries, at least 2. Need not be a power of two.
- `AFULL_THRESH`, default 3: `almost_full` asserts when level ≥ this value. Legal range 1..DEPTH.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: synchronous clear of all stored words.
- `upstream_rdy`  in  1: producer has a valid word on `upstream_data`.
- `upstream_data`  in  WIDTH: producer data.
- `upstream_acpt`  out  1: buffer can take a word this cycle.
- `downstream_rdy`  out  1: `downstream_data` holds a valid word.
- `downstream_data`  out  WIDTH: head-of-queue word.
- `downstream_acpt`  in  1: consumer takes the head word this cycle.
- `level`  out  $clog2(DEPTH+1): number of stored words.
- `almost_full`  out  1: level ≥ `AFULL_THRESH`.
- `downstream_perr`  out  1: parity mismatch on the head word.

## Operation
- **Transfer rules**
  - Push: `upstream_rdy` & `upstream_acpt` at a rising edge.
  - Pop: `downstream_rdy` & `downstream_acpt` at a rising edge.
- **Storage and pointers**
  - Storage is a circular array of DEPTH entries with write pointer `wp`, read pointer `rp` and count `cnt`.
  - Pointers wrap from DEPTH-1 to 0. Explicit compare is required; modulo-2^n wrap is forbidden for non-power-of-two DEPTH.
- **Update on each edge**
  - Push: write `upstream_data` at `wp`, then `wp++`.
  - Pop: `rp++`.
  - `cnt` change: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Output decodes** (from registered state plus `flush` only)
  - `upstream_acpt` = (`cnt` != DEPTH) & ~`flush`.
  - `downstream_rdy` = (`cnt` != 0) & ~`flush`.
  - `downstream_data` = `mem[rp]`. First-word fall-through.
  - `level` = `cnt`.
  - `almost_full` = (`cnt` ≥ `AFULL_THRESH`).
- **Flush:** with `flush` high at an edge, `wp`, `rp` and `cnt` go to 0. No transfer can occur in that cycle because both handshake outputs are forced low.
- **Full:** `upstream_acpt` is low even if a pop occurs in the same cycle. It rises in the cycle after the pop edge.
- **Empty:** `downstream_rdy` is low. A word pushed at edge N is presented after edge N; the buffer gives no same-cycle bypass.
- **Stability:** while `downstream_rdy` is high and `downstream_acpt` is low, `downstream_data` and `downstream_rdy` hold unchanged.
- **Out-of-range parameters:** `$error` at elaboration if DEPTH < 2 or `AFULL_THRESH` is outside 1..DEPTH.

## Timing
- **Reset values** (asynchronous, while `reset_n` low)
  - `wp` = `rp` = `cnt` = 0.
  - `downstream_rdy` = 0, `upstream_acpt` = 1 (unless `flush` is high), `level` = 0, `almost_full` = 0, `downstream_perr` = 0.
  - Storage array is not reset. `downstream_data` is don't-care while `downstream_rdy` is 0.
- **Reset mid-operation:** all words are discarded immediately. The first push after `reset_n` deasserts behaves as into an empty buffer.
- **Latency:** one edge from push to `downstream_rdy`.
- **Throughput:** one word per cycle sustained whenever 0 < `cnt` < DEPTH.
- **Occupancy flags:** `level` and `almost_full` change in the cycle following the causing edge.

## Configuration
- Macro `RDYACPT_FIFO_PARITY_EN`.
- **Defined**
  - Each entry stores WIDTH+1 bits: data plus even parity (^`upstream_data`) computed at push.
  - `downstream_perr` = `downstream_rdy` & (stored parity != ^`mem[rp]` data).
  - A bench-visible hook, `force` on the stored parity bit, must reach `downstream_perr`.
- **Undefined:** no parity storage, and `downstream_perr` is tied 0.
- Handshake and timing are identical either way.

## Test plan
- **Reset defaults:** reset asserted mid-stream with 3 words held → outputs immediately return to reset values. After release, a push of 0x11 is presented alone with `level` = 1.
- **Fill, stall and overflow (DEPTH=4, `AFULL_THRESH`=3)**
  - Push 0xA0..0xA3 with `downstream_acpt` = 0 → `almost_full` after 3rd push, `upstream_acpt` = 0 after 4th, `level` = 4.
  - A 5th `upstream_rdy` is not taken.
  - `downstream_data` holds 0xA0.
- **Streaming (DEPTH=4):** 1000 random words with `upstream_rdy` and `downstream_acpt` both held high → output order equals input order. After a 1-cycle startup, one word moves per cycle, and `level` settles at 1.
- **Wrap-around (DEPTH=3):** random rdy/acpt for 500 cycles → order preserved across pointer wraps, `level` equals the scoreboard count each cycle.
- **Simultaneous events**
  - Full buffer with `downstream_acpt` = 1 and `upstream_rdy` = 1 → pop only at edge N; push accepted at N+1.
  - `flush` with `upstream_rdy` = `downstream_acpt` = 1 → no transfer that cycle, `level` = 0 next cycle.
- **Parity (macro defined):** push 0x5A and corrupt the stored parity bit → `downstream_perr` = 1 while that word is at head, 0 after it is popped. With the macro undefined, `downstream_perr` stays 0.
